irs3_dac_scheduler: RTL and testbench
=====================================

# irs3_dac_scheduler

Arbitrated load controller for the IRS3 145-bit DAC/configuration shift register. Two requesters each present a complete 145-bit pattern: requester 0 is the host register interface, requester 1 is the autotrim feedback loop. The block grants one requester at a time with round-robin priority, serializes the pattern onto SCLK/SIN, and latches it with PCLK. It sits between the ATRI register/trim logic and the IRS3 DAC control pins, replacing manual VIO-driven loading.

## Interface
- `HALF_PERIOD`, default 255: SCLK half-period in CLK cycles, minus 1. Range 1–255.
- `NBITS`, default 145: shift register length. Fixed at 145 for IRS3; parameterized for bench speed.
- `CLK` in 1: system clock. The block has one clock.
- `RST` in 1: reset, synchronous, active-high.
- `REQ` in 2: per-requester load request; level, held until ACK.
- `PAT0` in NBITS: requester 0 pattern; bit NBITS-1 shifted first.
- `PAT1` in NBITS: requester 1 pattern.
- `ACK` in/out: out 2; one-CLK pulse to the granted requester when the load completes.
- `BUSY` out 1: high from grant through completion.
- `GRANT` out 1: index of the current/last granted requester.
- `SCLK`, `SIN`, `PCLK`, `REGCLR` out 1 each: IRS3 pins.
- `SHOUT` in 1: IRS3 serial output.
- `VERIFY_ERR` out 1: sticky readback mismatch. Cleared by RST or by the next grant.

## Operation
- Reset values: SCLK=0, SIN=0, PCLK=0, REGCLR=1, ACK=0, BUSY=0, GRANT=1, VERIFY_ERR=0. With GRANT=1 at reset, requester 0 wins the first arbitration.
- A tick is one CLK pulse every HALF_PERIOD+1 CLK cycles. All pin changes occur on ticks. The tick counter is free-running from reset.
- States:
  - CLEAR: REGCLR held for 2 ticks after RST deasserts, then released; go to IDLE.
  - IDLE: if any REQ bit is set, grant round-robin. The requester not equal to the last GRANT wins when both are set. Capture the pattern into the shift register, set BUSY, go to SHIFT.
  - SHIFT: each bit takes 2 ticks. Tick A: SIN=shreg[NBITS-1], SCLK=0. Tick B: SCLK=1, shift left, increment the bit counter. After bit NBITS-1 goes high, go to LATCH.
  - LATCH: SCLK=0, PCLK=1 for 2 ticks, PCLK=0. Then go to VERIFY if enabled, otherwise DONE.
  - DONE: one-CLK ACK[GRANT], BUSY=0, return to IDLE.
- A pattern is sampled only at grant. Changes on PAT* or deassertion of REQ while BUSY are ignored. Deasserting REQ does not abort a load.
- If a REQ bit is still set after its ACK, it is a new request and is arbitrated normally.
- RST mid-load aborts immediately: all outputs return to reset values and no ACK is issued.

## Timing
- Grant-to-first-SCLK-rise latency: 2 ticks. Capture happens in the IDLE CLK cycle; tick A follows.
- Full load without verify: 2·NBITS + 2 (latch) + 1 ticks, plus 1 CLK for ACK.
- The SIN setup and hold margin to each SCLK rise is one tick on each side.
- With HALF_PERIOD=255 and a 50 MHz CLK, SCLK ≈ 97.7 kHz.

## Configuration
- Macro `IRS3_DAC_READBACK_EN`.
- With the macro defined, the VERIFY state shifts NBITS more bits of all-zero SIN and samples SHOUT on each tick B. Sample k is compared to the pattern bit NBITS-1-k; any mismatch sets VERIFY_ERR. This adds 2·NBITS ticks before DONE.
- Without the macro, the VERIFY state, the comparator and the readback register are absent, and VERIFY_ERR is tied to 0.

## Structure
- The shared package `irs3_pkg` holds:
  - `IRS3_NBITS` = 145;
  - the state enum {CLEAR, IDLE, SHIFT, LATCH, VERIFY, DONE};
  - `IRS3_CLR_TICKS` = 2;
  - `IRS3_LATCH_TICKS` = 2.
- The natural sub-module is `irs3_tick_gen`: a tick-enable divider with HALF_PERIOD as its parameter. The arbiter and shift FSM stay in the top level.

## Test plan
- Basic load, HALF_PERIOD=1, NBITS=145, PAT0=145'h1_0000…0001 with REQ=01. Required: exactly 145 SCLK rises, SIN=1 on rises 1 and 145 only, one PCLK pulse 2 ticks wide, ACK=01 once, BUSY low afterwards.
- Simultaneous requests REQ=11, held throughout. Required: grants alternate 0,1,0,1 over 4 loads, each load captures its own PAT, and each ACK bit pulses twice.
- Reset mid-shift: assert RST after SCLK rise 60. Required: same-cycle return to reset values, no ACK, REGCLR pulse of 2 ticks after release, then a re-request completes a full 145-bit load.
- Pattern change during BUSY: change PAT0 after 10 bits. Required: the shifted data equals the pattern captured at grant.
- With `IRS3_DAC_READBACK_EN`, the bench model echoes SIN to SHOUT with a 145-bit delay. Clean echo: VERIFY_ERR=0. One flipped echo bit: VERIFY_ERR=1 at DONE, which clears on the next grant.

Source files
------------

// File: rtl/irs3_dac_scheduler_pkg.sv
// Shared constants, FSM state type and helpers for the IRS3 DAC scheduler.
// Optional readback verification is enabled with the macro IRS3_DAC_READBACK_EN.
package irs3_pkg;

    localparam int IRS3_NBITS       = 145;
    localparam int IRS3_CLR_TICKS   = 2;
    localparam int IRS3_LATCH_TICKS = 2;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        SHIFT,
        LATCH,
        VERIFY,
        DONE
    } irs3_state_e;

    // One-hot acknowledge vector for a requester index.
    function automatic logic [1:0] irs3_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/irs3_dac_scheduler_if.sv
// Requester-side bus of the IRS3 DAC scheduler: requests, patterns and status.
// The master modport is the requester side, the slave modport the scheduler.
interface irs3_dac_scheduler_if #(
    parameter int NBITS = 145
);
    logic [1:0]       req;
    logic [NBITS-1:0] pat0;
    logic [NBITS-1:0] pat1;
    logic [1:0]       ack;
    logic             busy;
    logic             grant;
    logic             verify_err;

    modport master (
        output req, pat0, pat1,
        input  ack, busy, grant, verify_err
    );

    modport slave (
        input  req, pat0, pat1,
        output ack, busy, grant, verify_err
    );
endinterface

// File: rtl/irs3_dac_scheduler_tick_gen.sv
// Tick-enable divider: one CLK-wide pulse every HALF_PERIOD+1 CLK cycles.
// The counter runs freely from reset so tick phase is fixed relative to RST.
module irs3_tick_gen #(
    parameter int HALF_PERIOD = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);
    logic [7:0] r_cnt;
    logic       w_wrap;

    assign w_wrap = (r_cnt == 8'(HALF_PERIOD));
    assign o_tick = w_wrap;

    // Free-running divide counter, wrapping at HALF_PERIOD.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/irs3_dac_scheduler.sv
// Round-robin arbitrated loader for the IRS3 145-bit DAC shift register.
// Serializes the granted pattern on SCLK/SIN (MSB first) and latches with PCLK.
// Define IRS3_DAC_READBACK_EN to add the SHOUT readback verify pass.
module irs3_dac_scheduler
    import irs3_pkg::*;
#(
    parameter int HALF_PERIOD = 255,
    parameter int NBITS       = IRS3_NBITS
) (
    input  logic                i_clk,
    input  logic                i_rst,
    irs3_dac_scheduler_if.slave io_bus,
    output logic                o_sclk,
    output logic                o_sin,
    output logic                o_pclk,
    output logic                o_regclr,
    input  logic                i_shout
);
    localparam int CW = $clog2(NBITS);

    irs3_state_e      r_state,   w_nxt_state;
    logic             r_grant,   w_nxt_grant;
    logic [NBITS-1:0] r_shreg,   w_nxt_shreg;
    logic [CW-1:0]    r_bit_cnt, w_nxt_bit_cnt;
    logic [1:0]       r_tcnt,    w_nxt_tcnt;
    logic             r_phase_b, w_nxt_phase_b;
    logic             r_sclk,    w_nxt_sclk;
    logic             r_sin,     w_nxt_sin;
    logic             r_pclk,    w_nxt_pclk;
    logic             r_regclr,  w_nxt_regclr;
    logic             w_tick;
    logic             w_win;
`ifdef IRS3_DAC_READBACK_EN
    logic [NBITS-1:0] r_rb,      w_nxt_rb;
    logic             r_verr,    w_nxt_verr;
`else
    logic             w_unused_shout;
    assign w_unused_shout = i_shout;
`endif

    irs3_tick_gen #(.HALF_PERIOD(HALF_PERIOD)) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    // Round-robin pick: with both requests pending, the one not granted last wins.
    always_comb begin
        w_win = io_bus.req[1];
        if (io_bus.req == 2'b11) begin
            w_win = ~r_grant;
        end
    end

    // Next-state and next-pin logic; pins only move on ticks.
    always_comb begin
        // NOTE: every next-value signal gets its default first; a branch that skipped one would infer a latch.
        w_nxt_state   = r_state;
        w_nxt_grant   = r_grant;
        w_nxt_shreg   = r_shreg;
        w_nxt_bit_cnt = r_bit_cnt;
        w_nxt_tcnt    = r_tcnt;
        w_nxt_phase_b = r_phase_b;
        w_nxt_sclk    = r_sclk;
        w_nxt_sin     = r_sin;
        w_nxt_pclk    = r_pclk;
        w_nxt_regclr  = r_regclr;
`ifdef IRS3_DAC_READBACK_EN
        w_nxt_rb      = r_rb;
        w_nxt_verr    = r_verr;
`endif
        unique case (r_state)
            CLEAR: begin
                if (w_tick) begin
                    if (r_tcnt == 2'(IRS3_CLR_TICKS - 1)) begin
                        w_nxt_regclr = 1'b0;
                        w_nxt_tcnt   = '0;
                        w_nxt_state  = IDLE;
                    end else begin
                        w_nxt_tcnt = r_tcnt + 2'd1;
                    end
                end
            end
            IDLE: begin
                if (|io_bus.req) begin
                    w_nxt_grant   = w_win;
                    w_nxt_shreg   = w_win ? io_bus.pat1 : io_bus.pat0;
                    w_nxt_bit_cnt = '0;
                    w_nxt_phase_b = 1'b0;
                    w_nxt_state   = SHIFT;
`ifdef IRS3_DAC_READBACK_EN
                    w_nxt_rb      = w_win ? io_bus.pat1 : io_bus.pat0;
                    w_nxt_verr    = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (!r_phase_b) begin
                        w_nxt_sin     = r_shreg[NBITS-1];
                        w_nxt_sclk    = 1'b0;
                        w_nxt_phase_b = 1'b1;
                    end else begin
                        w_nxt_sclk    = 1'b1;
                        w_nxt_shreg   = {r_shreg[NBITS-2:0], 1'b0};
                        w_nxt_phase_b = 1'b0;
                        if (r_bit_cnt == CW'(NBITS - 1)) begin
                            w_nxt_bit_cnt = '0;
                            w_nxt_tcnt    = '0;
                            w_nxt_state   = LATCH;
                        end else begin
                            w_nxt_bit_cnt = r_bit_cnt + 1'b1;
                        end
                    end
                end
            end
            LATCH: begin
                if (w_tick) begin
                    if (r_tcnt == 2'd0) begin
                        w_nxt_sclk = 1'b0;
                        w_nxt_pclk = 1'b1;
                        w_nxt_tcnt = 2'd1;
                    end else if (r_tcnt == 2'(IRS3_LATCH_TICKS)) begin
                        w_nxt_pclk = 1'b0;
                        w_nxt_tcnt = '0;
`ifdef IRS3_DAC_READBACK_EN
                        w_nxt_state = VERIFY;
`else
                        w_nxt_state = DONE;
`endif
                    end else begin
                        w_nxt_tcnt = r_tcnt + 2'd1;
                    end
                end
            end
`ifdef IRS3_DAC_READBACK_EN
            VERIFY: begin
                // Clock out the chip contents with zero SIN; SCLK is left high after
                // the last rise and drops on the next load's first tick.
                if (w_tick) begin
                    if (!r_phase_b) begin
                        w_nxt_sin     = 1'b0;
                        w_nxt_sclk    = 1'b0;
                        w_nxt_phase_b = 1'b1;
                    end else begin
                        w_nxt_sclk    = 1'b1;
                        w_nxt_phase_b = 1'b0;
                        w_nxt_rb      = {r_rb[NBITS-2:0], 1'b0};
                        if (i_shout != r_rb[NBITS-1]) begin
                            w_nxt_verr = 1'b1;
                        end
                        if (r_bit_cnt == CW'(NBITS - 1)) begin
                            w_nxt_bit_cnt = '0;
                            w_nxt_state   = DONE;
                        end else begin
                            w_nxt_bit_cnt = r_bit_cnt + 1'b1;
                        end
                    end
                end
            end
`endif
            DONE: begin
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // State and pin registers; RST aborts any load and restarts the REGCLR pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= CLEAR;
            r_grant   <= 1'b1;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_tcnt    <= '0;
            r_phase_b <= 1'b0;
            r_sclk    <= 1'b0;
            r_sin     <= 1'b0;
            r_pclk    <= 1'b0;
            r_regclr  <= 1'b1;
`ifdef IRS3_DAC_READBACK_EN
            r_rb      <= '0;
            r_verr    <= 1'b0;
`endif
        end else begin
            r_state   <= w_nxt_state;
            r_grant   <= w_nxt_grant;
            r_shreg   <= w_nxt_shreg;
            r_bit_cnt <= w_nxt_bit_cnt;
            r_tcnt    <= w_nxt_tcnt;
            r_phase_b <= w_nxt_phase_b;
            r_sclk    <= w_nxt_sclk;
            r_sin     <= w_nxt_sin;
            r_pclk    <= w_nxt_pclk;
            r_regclr  <= w_nxt_regclr;
`ifdef IRS3_DAC_READBACK_EN
            r_rb      <= w_nxt_rb;
            r_verr    <= w_nxt_verr;
`endif
        end
    end

    assign o_sclk   = r_sclk;
    assign o_sin    = r_sin;
    assign o_pclk   = r_pclk;
    assign o_regclr = r_regclr;

    assign io_bus.ack   = (r_state == DONE) ? irs3_onehot(r_grant) : 2'b00;
    assign io_bus.busy  = (r_state == SHIFT) || (r_state == LATCH) || (r_state == VERIFY);
    assign io_bus.grant = r_grant;
`ifdef IRS3_DAC_READBACK_EN
    assign io_bus.verify_err = r_verr;
`else
    assign io_bus.verify_err = 1'b0;
`endif
endmodule

// File: tb/tb_irs3_dac_scheduler.sv
// Self-checking bench for irs3_dac_scheduler (HALF_PERIOD=1, NBITS=145).
// A pin monitor rebuilds the shifted word from SCLK/SIN and models the IRS3
// register as a 145-bit SIN->SHOUT echo; expectations come from the load rules.
module tb_irs3_dac_scheduler;
    localparam int HP     = 1;
    localparam int NB     = 145;
    localparam int TK     = HP + 1;
    localparam int BUDGET = 4000;
`ifdef IRS3_DAC_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk, sin, pclk, regclr;
    logic shout = 1'b0;

    always #5 clk = ~clk;

    irs3_dac_scheduler_if #(.NBITS(NB)) bus ();

    irs3_dac_scheduler #(.HALF_PERIOD(HP), .NBITS(NB)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .io_bus   (bus),
        .o_sclk   (sclk),
        .o_sin    (sin),
        .o_pclk   (pclk),
        .o_regclr (regclr),
        .i_shout  (shout)
    );

    int vectors = 0;
    int miscompares = 0;

    // Pin monitor state (written only by the monitor).
    int          cyc = 0, rises = 0, pulses = 0, hi = 0, pwidth = 0;
    int          ack0 = 0, ack1 = 0, busy_cyc = 0, lat = 0;
    bit          lat_pend = 1'b0;
    logic        p_sclk = 1'b0, p_pclk = 1'b0, p_busy = 1'b0;
    logic [NB-1:0] cap = '0, snap = '0, echo = '0;
    int          flip_done_n = 0;
    // Written only by the stimulus.
    int          flip_req_n = 0, flip_idx = 0;

    always @(negedge clk) begin
        cyc++;
        if (sclk && !p_sclk) begin
            rises++;
            cap  = {cap[NB-2:0], sin};
            echo = {echo[NB-2:0], sin};
            if (lat_pend) begin
                lat      = cyc - busy_cyc;
                lat_pend = 1'b0;
            end
        end
        if (pclk && !p_pclk) begin
            pulses++;
            snap = cap;
            hi   = 0;
            if (flip_req_n != flip_done_n) begin
                echo[flip_idx] = ~echo[flip_idx];
                flip_done_n    = flip_req_n;
            end
        end
        if (pclk) hi++;
        if (!pclk && p_pclk) pwidth = hi;
        if (bus.busy && !p_busy) begin
            busy_cyc = cyc;
            lat_pend = 1'b1;
        end
        if (bus.ack[0]) ack0++;
        if (bus.ack[1]) ack1++;
        shout  = echo[NB-1];
        p_sclk = sclk;
        p_pclk = pclk;
        p_busy = bus.busy;
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkv(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] rand_pat();
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = 1'($urandom_range(0, 1));
        return p;
    endfunction

    task automatic check_reset_vals(input string tag);
        check1({tag, "_sclk"},   sclk,           1'b0);
        check1({tag, "_sin"},    sin,            1'b0);
        check1({tag, "_pclk"},   pclk,           1'b0);
        check1({tag, "_regclr"}, regclr,         1'b1);
        checkn({tag, "_ack"},    int'(bus.ack),  0);
        check1({tag, "_busy"},   bus.busy,       1'b0);
        check1({tag, "_grant"},  bus.grant,      1'b1);
        check1({tag, "_verr"},   bus.verify_err, 1'b0);
    endtask

    // Called at the negedge where RST was dropped; REGCLR must span two ticks.
    task automatic check_regclr(input string tag);
        int n = 0;
        while (regclr && n < 50) begin
            @(negedge clk);
            n++;
        end
        check1({tag, "_regclr_len"}, (n > TK) && (n <= 2 * TK), 1'b1);
    endtask

    task automatic wait_ack(input string tag, output logic [1:0] a);
        int n = 0;
        while (bus.ack == 2'b00 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        a = bus.ack;
        check1({tag, "_ack_seen"}, a != 2'b00, 1'b1);
    endtask

    task automatic wait_rises(input string tag, input int target);
        int n = 0;
        while (rises < target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check1({tag, "_rises_reached"}, rises >= target, 1'b1);
    endtask

    // Reference arbitration: the requester not granted last wins a tie.
    function automatic logic ref_winner(input logic [1:0] req, input logic last);
        return (req == 2'b11) ? ~last : req[1];
    endfunction

    initial begin
        logic [NB-1:0] p, ep;
        logic [1:0]    a;
        logic          m_last, w;
        int            r0, pu0, a00, a10;

        bus.req  = 2'b00;
        bus.pat0 = '0;
        bus.pat1 = '0;
        rst      = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        check_regclr("clear");
        m_last = 1'b1;

        // Basic load: marker bits at both ends, requester 0 only.
        p = '0;
        p[NB-1] = 1'b1;
        p[0]    = 1'b1;
        bus.pat0 = p;
        bus.req  = 2'b01;
        r0 = rises; pu0 = pulses; a00 = ack0; a10 = ack1;
        wait_ack("basic", a);
        bus.req = 2'b00;
        @(negedge clk);
        checkn("basic_ack", int'(a), 1);
        check1("basic_grant", bus.grant, ref_winner(2'b01, m_last));
        checkn("basic_rises", rises - r0, NB * (1 + RB));
        checkv("basic_data", snap, p);
        checkn("basic_sin_ones", $countones(snap), 2);
        checkn("basic_pclk_pulses", pulses - pu0, 1);
        checkn("basic_pclk_width", pwidth, 2 * TK);
        check1("basic_latency", (lat > TK) && (lat <= 2 * TK), 1'b1);
        checkn("basic_ack0_cnt", ack0 - a00, 1);
        checkn("basic_ack1_cnt", ack1 - a10, 0);
        check1("basic_busy_after", bus.busy, 1'b0);
        checkn("basic_ack_after", int'(bus.ack), 0);
        m_last = 1'b0;

        // Both requesters held: grants alternate, each load carries its own pattern.
        bus.pat0 = rand_pat();
        bus.pat1 = rand_pat();
        bus.req  = 2'b11;
        a00 = ack0; a10 = ack1;
        for (int i = 0; i < 4; i++) begin
            w  = ref_winner(2'b11, m_last);
            ep = w ? bus.pat1 : bus.pat0;
            wait_ack("rr", a);
            if (i == 3) bus.req = 2'b00;
            bus.pat0 = rand_pat();
            bus.pat1 = rand_pat();
            @(negedge clk);
            checkn("rr_ack", int'(a), w ? 2 : 1);
            check1("rr_grant", bus.grant, w);
            checkv("rr_data", snap, ep);
            m_last = w;
        end
        checkn("rr_ack0_cnt", ack0 - a00, 2);
        checkn("rr_ack1_cnt", ack1 - a10, 2);

        // Pattern and REQ change while busy must not affect the load.
        p = rand_pat();
        bus.pat0 = p;
        bus.req  = 2'b01;
        w = ref_winner(2'b01, m_last);
        r0 = rises;
        wait_rises("chg", r0 + 10);
        bus.pat0 = ~p;
        bus.req  = 2'b00;
        check1("chg_busy", bus.busy, 1'b1);
        wait_ack("chg", a);
        @(negedge clk);
        checkn("chg_ack", int'(a), 1);
        checkv("chg_data", snap, p);
        m_last = w;

        // Reset in the middle of the shift aborts without ACK.
        bus.pat1 = rand_pat();
        bus.req  = 2'b10;
        r0 = rises; a00 = ack0; a10 = ack1; pu0 = pulses;
        wait_rises("rstmid", r0 + 60);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rstmid");
        bus.req = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_regclr("rstmid");
        repeat (20) @(negedge clk);
        checkn("rstmid_no_ack", (ack0 - a00) + (ack1 - a10), 0);
        checkn("rstmid_no_pclk", pulses - pu0, 0);
        m_last = 1'b1;
        p = rand_pat();
        bus.pat1 = p;
        bus.req  = 2'b10;
        r0 = rises;
        wait_ack("rereq", a);
        bus.req = 2'b00;
        @(negedge clk);
        checkn("rereq_ack", int'(a), 2);
        checkn("rereq_rises", rises - r0, NB * (1 + RB));
        checkv("rereq_data", snap, p);
        m_last = 1'b1;

`ifdef IRS3_DAC_READBACK_EN
        // Clean echo: no readback error.
        bus.pat0 = rand_pat();
        bus.req  = 2'b01;
        wait_ack("rb_clean", a);
        bus.req = 2'b00;
        check1("rb_clean_verr", bus.verify_err, 1'b0);
        @(negedge clk);
        // One corrupted echo bit: sticky error at DONE.
        flip_idx = $urandom_range(0, NB - 1);
        flip_req_n++;
        bus.pat1 = rand_pat();
        bus.req  = 2'b10;
        wait_ack("rb_flip", a);
        bus.req = 2'b00;
        check1("rb_flip_verr", bus.verify_err, 1'b1);
        repeat (5) @(negedge clk);
        check1("rb_flip_sticky", bus.verify_err, 1'b1);
        // Next grant clears it.
        bus.pat0 = rand_pat();
        bus.req  = 2'b01;
        begin
            int n = 0;
            while (!bus.busy && n < BUDGET) begin
                @(negedge clk);
                n++;
            end
        end
        check1("rb_regrant_busy", bus.busy, 1'b1);
        check1("rb_regrant_clr", bus.verify_err, 1'b0);
        wait_ack("rb_regrant", a);
        bus.req = 2'b00;
        check1("rb_regrant_verr", bus.verify_err, 1'b0);
`else
        check1("no_rb_verr", bus.verify_err, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
